// File: rtl/conv3x3_engine.sv
// conv3x3_engine: 3-stage 3x3 signed convolution with runtime-loaded taps/bias, column gating and saturation.
// Optional CONV_RELU_EN macro clamps negative results to zero after saturation.
module conv3x3_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 28,
  parameter int FRAC_SHIFT = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wt_we,
  input  logic [3:0]                   wt_addr,
  input  logic signed [DATA_WIDTH-1:0] wt_data,
  input  logic                         bias_we,
  input  logic signed [DATA_WIDTH-1:0] bias_data,
  input  logic                         frame_start,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] px0, px1, px2, px3, px4, px5, px6, px7, px8,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_px,
  output logic                         out_sat,
  output logic                         busy
);
  localparam int PW = 2*DATA_WIDTH;
  localparam int CW = ($clog2(IMG_WIDTH) < 2) ? 2 : $clog2(IMG_WIDTH);
  localparam logic signed [ACC_WIDTH-1:0] SMAX = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SMIN = ~SMAX;
  localparam logic signed [ACC_WIDTH-1:0] RND  = ACC_WIDTH'((2**FRAC_SHIFT)/2);
  logic signed [DATA_WIDTH-1:0] px [9];
  logic signed [DATA_WIDTH-1:0] w_q [9], w_d [9];
  logic signed [DATA_WIDTH-1:0] bias_q, bias_d;
  logic [CW-1:0] col_q, col_d, col_eff;
  logic accept;
  logic signed [PW-1:0] prod_q [9], prod_d [9];
  logic signed [ACC_WIDTH-1:0] row_q [3], row_d [3];
  logic v1_q, v1_d, v2_q, v2_d, out_valid_q, out_valid_d;
  logic signed [DATA_WIDTH-1:0] out_px_q, out_px_d, sat_v;
  logic out_sat_q, out_sat_d, clip;
  logic signed [ACC_WIDTH-1:0] acc, res;
  always_comb begin
    px = '{px0, px1, px2, px3, px4, px5, px6, px7, px8};
    w_d = w_q;
    if (wt_we && wt_addr < 4'd9) w_d[wt_addr] = wt_data;
    bias_d = bias_we ? bias_data : bias_q;
    // frame_start with a beat makes that beat column 0
    col_eff = frame_start ? '0 : col_q;
    accept = in_valid && col_eff >= CW'(2);
    col_d = in_valid ? ((col_eff == CW'(IMG_WIDTH-1)) ? '0 : col_eff + CW'(1)) : col_eff;
    for (int i = 0; i < 9; i++) prod_d[i] = PW'(px[i]) * PW'(w_q[i]);
    for (int i = 0; i < 3; i++)
      row_d[i] = ACC_WIDTH'(prod_q[3*i]) + ACC_WIDTH'(prod_q[3*i+1]) + ACC_WIDTH'(prod_q[3*i+2]);
    v1_d = accept;
    v2_d = v1_q;
    out_valid_d = v2_q;
    acc = row_q[0] + row_q[1] + row_q[2] + (ACC_WIDTH'(bias_q) <<< FRAC_SHIFT) + RND;
    res = acc >>> FRAC_SHIFT;
    clip = (res > SMAX) || (res < SMIN);
    sat_v = (res > SMAX) ? SMAX[DATA_WIDTH-1:0] : (res < SMIN) ? SMIN[DATA_WIDTH-1:0] : res[DATA_WIDTH-1:0];
`ifdef CONV_RELU_EN
    sat_v = sat_v[DATA_WIDTH-1] ? '0 : sat_v;
`else
    sat_v = sat_v;
`endif
    out_px_d = v2_q ? sat_v : out_px_q;
    out_sat_d = v2_q ? clip : out_sat_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_q <= '{default: '0};
      bias_q <= '0;
      col_q <= '0;
      prod_q <= '{default: '0};
      row_q <= '{default: '0};
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_px_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      w_q <= w_d;
      bias_q <= bias_d;
      col_q <= col_d;
      prod_q <= prod_d;
      row_q <= row_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      out_valid_q <= out_valid_d;
      out_px_q <= out_px_d;
      out_sat_q <= out_sat_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_px = out_px_q;
  assign out_sat = out_sat_q;
  assign busy = v1_q | v2_q | out_valid_q;
endmodule

// File: tb/tb_conv3x3_engine.sv
// tb_conv3x3_engine: directed checks on two engines (FRAC_SHIFT 0 and 2, IMG_WIDTH 5) sharing one input stream.
module tb_conv3x3_engine;
  logic clk, reset_n, wt_we, bias_we, frame_start, in_valid;
  logic [3:0] wt_addr;
  logic signed [15:0] wt_data, bias_data;
  logic signed [15:0] px [9];
  logic ov0, ov2, sat0, sat2, busy0, busy2;
  logic signed [15:0] opx0, opx2;
  int tests = 0, fails = 0;

  conv3x3_engine #(.DATA_WIDTH(16), .IMG_WIDTH(5), .FRAC_SHIFT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .bias_we(bias_we), .bias_data(bias_data), .frame_start(frame_start), .in_valid(in_valid),
    .px0(px[0]), .px1(px[1]), .px2(px[2]), .px3(px[3]), .px4(px[4]), .px5(px[5]), .px6(px[6]),
    .px7(px[7]), .px8(px[8]), .out_valid(ov0), .out_px(opx0), .out_sat(sat0), .busy(busy0));

  conv3x3_engine #(.DATA_WIDTH(16), .IMG_WIDTH(5), .FRAC_SHIFT(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .bias_we(bias_we), .bias_data(bias_data), .frame_start(frame_start), .in_valid(in_valid),
    .px0(px[0]), .px1(px[1]), .px2(px[2]), .px3(px[3]), .px4(px[4]), .px5(px[5]), .px6(px[6]),
    .px7(px[7]), .px8(px[8]), .out_valid(ov2), .out_px(opx2), .out_sat(sat2), .busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr_tap(input int a, input int v);
    wt_we = 1'b1; wt_addr = 4'(a); wt_data = 16'(v);
    step();
    wt_we = 1'b0;
  endtask

  task automatic wr_bias(input int v);
    bias_we = 1'b1; bias_data = 16'(v);
    step();
    bias_we = 1'b0;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 9; i++) px[i] = 16'(v);
  endtask

  // col0, col1 (dropped), col2 (accepted) with the current px, then wait for the result
  task automatic window();
    in_valid = 1'b1; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    step();
    in_valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    reset_n = 1'b0; wt_we = 1'b0; bias_we = 1'b0; frame_start = 1'b0; in_valid = 1'b0;
    wt_addr = '0; wt_data = '0; bias_data = '0;
    set_all(0);
    #12;
    chk("rst_valid", ov0, 0);
    chk("rst_px", opx0, 0);
    chk("rst_sat", sat0, 0);
    chk("rst_busy", busy0, 0);
    reset_n = 1'b1;
    step();

    // stream: only the centre tap, centre pixel = column
    wr_tap(4, 1);
    set_all(7);
    for (int i = 0; i < 17; i++) begin
      if (i < 15) begin
        in_valid = 1'b1; frame_start = (i == 0); px[4] = 16'(i % 5);
      end else begin
        in_valid = 1'b0; frame_start = 1'b0;
      end
      step();
      if (i >= 2) begin
        chk($sformatf("stream_valid_%0d", i - 2), ov0, ((i - 2) % 5 >= 2) ? 1 : 0);
        if ((i - 2) % 5 >= 2) chk($sformatf("stream_px_%0d", i - 2), opx0, (i - 2) % 5);
      end else chk($sformatf("stream_early_%0d", i), ov0, 0);
    end
    step();
    chk("stream_idle_busy", busy0, 0);

    // tap write on the same edge as an accepted beat
    px[4] = 16'sd10;
    in_valid = 1'b1; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    wt_we = 1'b1; wt_addr = 4'd4; wt_data = 16'sd3;
    step();
    wt_we = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    chk("wr_old_valid", ov0, 1);
    chk("wr_old_px", opx0, 10);
    chk("wr_old_px_fs2", opx2, 3);
    step();
    chk("wr_new_valid", ov0, 1);
    chk("wr_new_px", opx0, 30);
    chk("wr_new_px_fs2", opx2, 8);

    // all taps 1, bias 2
    for (int i = 0; i < 9; i++) wr_tap(i, 1);
    wr_bias(2);
    px = '{16'sd0, 16'sd1, 16'sd2, 16'sd5, 16'sd6, 16'sd7, 16'sd10, 16'sd11, 16'sd12};
    window();
    chk("win_valid", ov0, 1);
    chk("win_px", opx0, 56);
    chk("win_sat", sat0, 0);
    chk("win_px_fs2", opx2, 16);
    chk("win_busy", busy0, 1);
    step();
    chk("win_pulse", ov0, 0);
    chk("win_hold", opx0, 56);

    // rounding with FRAC_SHIFT=2
    wr_bias(0);
    px = '{16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd0, 16'sd0, 16'sd0};
    window();
    chk("rnd_pos_fs2", opx2, 2);
    chk("rnd_pos_fs0", opx0, 6);
    px = '{-16'sd1, -16'sd1, -16'sd1, -16'sd1, -16'sd1, -16'sd1, 16'sd0, 16'sd0, 16'sd0};
    window();
    chk("rnd_neg_fs2", opx2, -1);
`ifdef CONV_RELU_EN
    chk("rnd_neg_fs0", opx0, 0);
`else
    chk("rnd_neg_fs0", opx0, -6);
`endif

    // saturation
    set_all(32767);
    window();
    chk("sat_hi_px", opx0, 32767);
    chk("sat_hi_flag", sat0, 1);
    chk("sat_hi_px_fs2", opx2, 32767);
    chk("sat_hi_flag_fs2", sat2, 1);
    set_all(-32768);
    window();
`ifdef CONV_RELU_EN
    chk("sat_lo_px", opx0, 0);
    chk("sat_lo_px_fs2", opx2, 0);
`else
    chk("sat_lo_px", opx0, -32768);
    chk("sat_lo_px_fs2", opx2, -32768);
`endif
    chk("sat_lo_flag", sat0, 1);
    chk("sat_lo_flag_fs2", sat2, 1);

    // reset with three beats in flight
    set_all(3);
    in_valid = 1'b1; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    in_valid = 1'b0;
    chk("flight_valid", ov0, 1);
    chk("flight_px", opx0, 27);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_valid", ov0, 0);
    chk("arst_busy", busy0, 0);
    chk("arst_px", opx0, 0);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("post_rst_quiet_%0d", i), ov0, 0);
    end
    set_all(5);
    window();
    chk("post_rst_valid", ov0, 1);
    chk("post_rst_px", opx0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
